// File: rtl/parity_pkg.sv
// Shared types and helpers for the frame parity arbiter.
package parity_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 8;
  localparam int RR_MAX     = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_e;

  // First set bit of valid[n-1:0], searching upward from ptr with wrap.
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [2:0] ptr,
                                         input int n);
    logic [2:0]  pick;
    logic        found;
    logic [31:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = 32'((int'(ptr) + i) % n);
      if (i < n && !found && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/parity_word_reduce.sv
// Combinational XOR reduction of one word to a single parity bit.
module parity_word_reduce #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] word_i,
  output logic              par_o
);
  assign par_o = ^word_i;
endmodule

// File: rtl/parity_frame_arbiter.sv
// Round-robin frame arbiter sharing one word-parity reducer among NUM_REQ producers.
module parity_frame_arbiter
  import parity_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  input  logic [NUM_REQ-1:0]        req_odd_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic                      res_parity_o,
  output logic [IDW-1:0]            res_id_o,
  output logic [CNT_W-1:0]          res_words_o
);
  state_e           state_q, state_d;
  logic [IDW-1:0]   owner_q, rr_ptr_q, grant, rr_next;
  logic             odd_q, acc_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             res_valid_q, res_parity_q;
  logic [IDW-1:0]   res_id_q;
  logic [CNT_W-1:0] res_words_q;

  logic [DATA_W-1:0] own_word;
  logic              own_valid, own_last, grant_odd, word_par, accept;

  assign grant = IDW'(rr_pick(RR_MAX'(req_valid_i), 3'(rr_ptr_q), NUM_REQ));

  // Owner-side mux feeds the single shared reducer.
  always_comb begin
    own_word  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    grant_odd = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDW'(k) == owner_q) begin
        own_word  = req_data_i[k*DATA_W +: DATA_W];
        own_valid = req_valid_i[k];
        own_last  = req_last_i[k];
      end
      if (IDW'(k) == grant) grant_odd = req_odd_i[k];
    end
  end

  parity_word_reduce #(.DATA_W(DATA_W)) u_reduce (
    .word_i (own_word),
    .par_o  (word_par)
  );

  assign accept  = (state_q == BUSY) && own_valid;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign rr_next = (owner_q == IDW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_valid_i)         state_d = BUSY;
      BUSY:    if (accept && own_last)   state_d = RESULT;
      RESULT:  if (res_ready_i)          state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (state_q == BUSY && IDW'(k) == owner_q) req_ready_o[k] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      odd_q        <= 1'b0;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      res_valid_q  <= 1'b0;
      res_parity_q <= 1'b0;
      res_id_q     <= '0;
      res_words_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_valid_i) begin
          owner_q <= grant;
          odd_q   <= grant_odd;
          acc_q   <= 1'b0;
          cnt_q   <= '0;
        end
        BUSY: if (accept) begin
          acc_q <= acc_q ^ word_par;
          cnt_q <= cnt_inc;
          if (own_last) begin
            res_parity_q <= acc_q ^ word_par ^ odd_q;
            res_words_q  <= cnt_inc;
            res_id_q     <= owner_q;
            res_valid_q  <= 1'b1;
            rr_ptr_q     <= rr_next;
          end
        end
        RESULT: if (res_valid_q && res_ready_i) res_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign res_valid_o  = res_valid_q;
  assign res_parity_o = res_parity_q;
  assign res_id_o     = res_id_q;
  assign res_words_o  = res_words_q;
endmodule

// File: tb/tb_parity_frame_arbiter.sv
// Directed bench for parity_frame_arbiter: latency, multi-word, round-robin, backpressure, reset, saturation.
module tb_parity_frame_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_last, req_odd, req_ready;
  logic [63:0] req_data;
  logic        res_valid, res_ready, res_parity;
  logic [1:0]  res_id;
  logic [7:0]  res_words;

  logic [3:0]  v2, l2, o2, rdy2;
  logic [63:0] d2;
  logic        rv2, rp2;
  logic [1:0]  rid2;
  logic [1:0]  rw2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_arbiter #(.NUM_REQ(4), .DATA_W(16), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_odd_i(req_odd), .req_ready_o(req_ready),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_parity_o(res_parity),
    .res_id_o(res_id), .res_words_o(res_words)
  );

  parity_frame_arbiter #(.NUM_REQ(4), .DATA_W(16), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v2), .req_data_i(d2),
    .req_last_i(l2), .req_odd_i(o2), .req_ready_o(rdy2),
    .res_valid_o(rv2), .res_ready_i(1'b1), .res_parity_o(rp2),
    .res_id_o(rid2), .res_words_o(rw2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until a result appears, dropping valid for any requester whose last word was accepted.
  task automatic wait_result(input string tag);
    logic       got;
    logic [3:0] acc;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      acc = req_ready & req_valid;
      step();
      req_valid = req_valid & ~acc;
      got = res_valid;
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_odd = '0; req_data = '0;
    res_ready = 1'b1; v2 = '0; l2 = '0; o2 = '0; d2 = '0;
    step(); step();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_parity", 32'(res_parity), 0);
    chk("rst_id", 32'(res_id), 0);
    chk("rst_words", 32'(res_words), 0);
    rst = 1'b0;

    // Single-word frame from requester 0: latency check.
    req_valid = 4'b0001; req_last = 4'b0001; req_data[15:0] = 16'h0001;
    step();
    chk("t1_ready_c1", 32'(req_ready), 32'b0001);
    chk("t1_valid_c1", 32'(res_valid), 0);
    step();
    req_valid = '0;
    chk("t1_valid_c2", 32'(res_valid), 1);
    chk("t1_parity", 32'(res_parity), 1);
    chk("t1_id", 32'(res_id), 0);
    chk("t1_words", 32'(res_words), 1);
    step();
    chk("t1_valid_c3", 32'(res_valid), 0);

    // Three-word odd-parity frame from requester 1.
    req_valid = 4'b0010; req_last = 4'b0000; req_odd = 4'b0010; req_data[31:16] = 16'h00FF;
    step();
    chk("t2_ready", 32'(req_ready), 32'b0010);
    step(); req_data[31:16] = 16'h0F0F;
    step(); req_data[31:16] = 16'h8001; req_last = 4'b0010;
    step(); req_valid = '0; req_last = '0; req_odd = '0;
    chk("t2_valid", 32'(res_valid), 1);
    chk("t2_parity", 32'(res_parity), 1);
    chk("t2_id", 32'(res_id), 1);
    chk("t2_words", 32'(res_words), 3);
    step();

    // Round robin: 0 and 2 after reset, then 0,1,2.
    rst = 1'b1; step(); rst = 1'b0;
    req_data = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
    req_last = 4'b1111; req_valid = 4'b0101;
    wait_result("rr_a"); chk("rr_a_id", 32'(res_id), 0); chk("rr_a_par", 32'(res_parity), 1);
    wait_result("rr_b"); chk("rr_b_id", 32'(res_id), 2);
    req_valid = 4'b0111;
    wait_result("rr_c"); chk("rr_c_id", 32'(res_id), 0);
    wait_result("rr_d"); chk("rr_d_id", 32'(res_id), 1);
    wait_result("rr_e"); chk("rr_e_id", 32'(res_id), 2);
    step();

    // Backpressure on requester 3 (next in rotation).
    res_ready = 1'b0; req_data[63:48] = 16'h0003; req_odd = 4'b1000; req_valid = 4'b1000;
    wait_result("bp");
    req_odd = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_parity", 32'(res_parity), 1);
      chk("bp_id", 32'(res_id), 3);
      chk("bp_words", 32'(res_words), 1);
      chk("bp_ready", 32'(req_ready), 0);
    end
    res_ready = 1'b1;
    step();
    chk("bp_consumed", 32'(res_valid), 0);

    // Reset mid-frame, then restart the 4-word frame.
    req_data[15:0] = 16'hFFFF; req_last = '0; req_valid = 4'b0001;
    step(); step(); step();
    rst = 1'b1; step();
    chk("mr_ready", 32'(req_ready), 0);
    chk("mr_valid", 32'(res_valid), 0);
    chk("mr_parity", 32'(res_parity), 0);
    chk("mr_id", 32'(res_id), 0);
    chk("mr_words", 32'(res_words), 0);
    rst = 1'b0;
    step();
    chk("mr_regrant", 32'(req_ready), 32'b0001);
    step(); step(); step();
    req_data[15:0] = 16'h0001; req_last = 4'b0001;
    step(); req_valid = '0; req_last = '0;
    chk("mr_res_valid", 32'(res_valid), 1);
    chk("mr_res_parity", 32'(res_parity), 1);
    chk("mr_res_words", 32'(res_words), 4);
    step();

    // CNT_W=2 build: 5 words saturate to 3.
    v2 = 4'b0001; d2[15:0] = 16'h0003;
    step();
    chk("sat_ready", 32'(rdy2), 32'b0001);
    step(); step(); step(); step();
    l2 = 4'b0001;
    step(); v2 = '0; l2 = '0;
    chk("sat_valid", 32'(rv2), 1);
    chk("sat_words", 32'(rw2), 3);
    chk("sat_parity", 32'(rp2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
